// File: rtl/agdc_pkg.sv
// Shared state codes, direction encoding and helpers for the garage door controller.
package agdc_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_MV_DN = 3'd1,
        ST_MV_UP = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic logic is_moving(input state_e s);
        return (s == ST_MV_UP) || (s == ST_MV_DN);
    endfunction

endpackage

// File: rtl/agdc_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-high counter, one pulse per press.
module agdc_debounce
    import agdc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter saturates at DEBOUNCE_CYCLES so a held button cannot re-fire.
    always_comb begin
        cnt_d = cnt_q;
        if (!s2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= din;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
        end
    end

    assign pulse = s2_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/agdc_ctrl_param.sv
// Garage door controller: limit-driven motor FSM with stop/reverse, obstruction
// handling, motor-run watchdog and latched fault.
module agdc_ctrl_param
    import agdc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          OBSTRUCT_REV    = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               UP_Max,
    input  logic               DN_Max,
    input  logic               Activate,
    input  logic               Obstruct,
    input  logic               Clear,
    output logic               UP_M,
    output logic               DN_M,
    output logic               Fault,
    output logic [STATE_W-1:0] State
);

    localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          rst_meta_q;
    logic          rst_sync_q;
    logic          act_pulse;
    state_e        state_q;
    state_e        state_d;
    logic          dir_q;
    logic          dir_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          up_m_q;
    logic          dn_m_q;
    logic          fault_q;
    logic          both_lim;
    logic          timeout;

    // Reset asserts immediately, releases two clocks after RST rises.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    agdc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK  (CLK),
        .RST  (rst_sync_q),
        .din  (Activate),
        .pulse(act_pulse)
    );

    assign both_lim = UP_Max & DN_Max;
    assign timeout  = (timer_q == T_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (both_lim)       state_d = ST_FAULT;
                else if (act_pulse) state_d = UP_Max ? ST_MV_DN : ST_MV_UP;
            end
            ST_MV_DN: begin
                if (both_lim)       state_d = ST_FAULT;
                else if (timeout)   state_d = ST_FAULT;
                else if (DN_Max)    state_d = ST_IDLE;
                else if (Obstruct)  state_d = OBSTRUCT_REV ? ST_MV_UP : ST_STOP;
                else if (act_pulse) state_d = ST_STOP;
            end
            ST_MV_UP: begin
                if (both_lim)       state_d = ST_FAULT;
                else if (timeout)   state_d = ST_FAULT;
                else if (UP_Max)    state_d = ST_IDLE;
                else if (act_pulse) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (both_lim)       state_d = ST_FAULT;
                else if (act_pulse) state_d = (dir_q == DIR_UP) ? ST_MV_DN : ST_MV_UP;
            end
            ST_FAULT: begin
                if (Clear && !both_lim) state_d = ST_IDLE;
            end
            default: state_d = ST_FAULT;
        endcase
    end

    // Any state change into a moving state (including reversal) restarts the watchdog.
    always_comb begin
        timer_d = '0;
        if (is_moving(state_d) && (state_d == state_q)) begin
            timer_d = timeout ? timer_q : timer_q + 1'b1;
        end
    end

    always_comb begin
        dir_d = dir_q;
        if (state_d == ST_MV_UP)      dir_d = DIR_UP;
        else if (state_d == ST_MV_DN) dir_d = DIR_DN;
    end

    always_ff @(posedge CLK or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            timer_q <= '0;
            up_m_q  <= 1'b0;
            dn_m_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            up_m_q  <= (state_d == ST_MV_UP);
            dn_m_q  <= (state_d == ST_MV_DN);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign UP_M  = up_m_q;
    assign DN_M  = dn_m_q;
    assign Fault = fault_q;
    assign State = state_q;

endmodule

// File: tb/tb_agdc_ctrl_param.sv
// Directed self-checking bench for agdc_ctrl_param (TIMEOUT 16, DEBOUNCE 2, reverse on obstruct).
module tb_agdc_ctrl_param;

    logic       clk;
    logic       rst_n;
    logic       up_max;
    logic       dn_max;
    logic       activate;
    logic       obstruct;
    logic       clear;
    logic       up_m;
    logic       dn_m;
    logic       fault;
    logic [2:0] state;

    int n_assert = 0;
    int n_fail   = 0;

    agdc_ctrl_param #(
        .TIMEOUT_CYCLES (16),
        .DEBOUNCE_CYCLES(2),
        .OBSTRUCT_REV   (1'b1)
    ) dut (
        .CLK     (clk),
        .RST     (rst_n),
        .UP_Max  (up_max),
        .DN_Max  (dn_max),
        .Activate(activate),
        .Obstruct(obstruct),
        .Clear   (clear),
        .UP_M    (up_m),
        .DN_M    (dn_m),
        .Fault   (fault),
        .State   (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse is live after the third edge; the FSM acts on the fourth.
    task automatic press();
        activate = 1'b1;
        step(3);
        activate = 1'b0;
        step(1);
    endtask

    initial begin
        rst_n = 1'b0; up_max = 1'b1; dn_max = 1'b0;
        activate = 1'b0; obstruct = 1'b0; clear = 1'b0;
        step(3);
        chk("rst_state", state, 0);
        chk("rst_up_m", up_m, 0);
        chk("rst_dn_m", dn_m, 0);
        chk("rst_fault", fault, 0);
        rst_n = 1'b1;
        step(3);
        chk("idle_after_rst", state, 0);

        // 1: held Activate -> single press -> close; lower limit -> idle
        activate = 1'b1;
        step(3);
        chk("t1_no_motor_yet", dn_m, 0);
        step(1);
        chk("t1_dn_m", dn_m, 1);
        chk("t1_state", state, 1);
        chk("t1_up_m", up_m, 0);
        up_max = 1'b0;
        step(2);
        activate = 1'b0;
        step(3);
        chk("t1_single_pulse", state, 1);
        dn_max = 1'b1;
        chk("t1_dn_m_latency", dn_m, 1);
        step(1);
        chk("t1_limit_state", state, 0);
        chk("t1_limit_dn_m", dn_m, 0);

        // 2: obstruction while closing reverses; watchdog restarts on reversal
        dn_max = 1'b0; up_max = 1'b1;
        step(2);
        press();
        chk("t2_closing", state, 1);
        up_max = 1'b0;
        step(2);
        obstruct = 1'b1;
        step(1);
        obstruct = 1'b0;
        chk("t2_rev_state", state, 2);
        chk("t2_rev_up_m", up_m, 1);
        chk("t2_rev_dn_m", dn_m, 0);
        obstruct = 1'b1;
        step(1);
        obstruct = 1'b0;
        chk("t2_obstruct_ignored_up", state, 2);

        // 4: watchdog timeout 16 cycles after entering MV_UP
        step(14);
        chk("t4_before_timeout", state, 2);
        chk("t4_before_timeout_up_m", up_m, 1);
        step(1);
        chk("t4_timeout_state", state, 4);
        chk("t4_timeout_fault", fault, 1);
        chk("t4_timeout_up_m", up_m, 0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t4_clear_state", state, 0);
        chk("t4_clear_fault", fault, 0);

        // 3: no limits -> up; press -> stop; press -> down (reverse of up)
        step(2);
        press();
        chk("t3_safe_dir", state, 2);
        step(2);
        press();
        chk("t3_stop_state", state, 3);
        chk("t3_stop_up_m", up_m, 0);
        chk("t3_stop_dn_m", dn_m, 0);
        step(2);
        press();
        chk("t3_reverse_state", state, 1);
        chk("t3_reverse_dn_m", dn_m, 1);
        dn_max = 1'b1;
        step(1);
        chk("t3_closed", state, 0);

        // limit and press in the same cycle: limit wins
        step(2);
        press();
        chk("sim_open_from_closed", state, 2);
        dn_max = 1'b0;
        step(2);
        activate = 1'b1;
        step(3);
        up_max = 1'b1;
        activate = 1'b0;
        step(1);
        chk("sim_limit_wins", state, 0);
        chk("sim_up_m", up_m, 0);
        step(4);
        chk("sim_pulse_dropped", state, 0);

        // 5: both limits -> fault; clear blocked while both high
        dn_max = 1'b1;
        step(1);
        chk("t5_fault_state", state, 4);
        chk("t5_fault_flag", fault, 1);
        clear = 1'b1;
        step(2);
        chk("t5_clear_blocked", state, 4);
        up_max = 1'b0;
        step(1);
        clear = 1'b0;
        chk("t5_clear_ok", state, 0);
        chk("t5_clear_fault", fault, 0);

        // 6: one-cycle glitch ignored; reset mid-move kills motor at once
        step(2);
        activate = 1'b1;
        step(1);
        activate = 1'b0;
        step(5);
        chk("t6_glitch", state, 0);
        dn_max = 1'b0; up_max = 1'b1;
        press();
        chk("t6_moving_dn", dn_m, 1);
        up_max = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_dn_m", dn_m, 0);
        chk("t6_async_state", state, 0);
        chk("t6_async_up_m", up_m, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("t6_idle_after_release", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
